// File: rtl/pwl_exp_pipe.sv
// Pipelined piecewise-linear exp(angle) with run-time programmable segment tables.
// Define PWL_EXP_ROUND_EN to round half up before dropping fractional product bits.
module pwl_exp_pipe #(
    parameter int unsigned XY_SZ    = 8,
    parameter int unsigned FRAC_IN  = 7,
    parameter int unsigned FRAC_OUT = 5,
    parameter int unsigned SEG_NUM  = 8,
    localparam int unsigned SEG_W   = $clog2(SEG_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XY_SZ-1:0] in_angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XY_SZ-1:0] out_exp,
    output logic             out_sat,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [SEG_W-1:0] cfg_addr,
    input  logic [XY_SZ-1:0] cfg_data
);

    if (SEG_NUM < 2 || SEG_NUM > 32 || (SEG_NUM & (SEG_NUM - 1)) != 0) begin : g_bad_seg
        $error("SEG_NUM must be a power of 2 in 2..32");
    end
    if (FRAC_IN == 0 || FRAC_IN >= XY_SZ || FRAC_OUT >= XY_SZ) begin : g_bad_frac
        $error("FRAC_IN/FRAC_OUT out of range for XY_SZ");
    end

    // Factory tables exist only for the 8-segment, 8-bit build; entry 0 sits in the low byte.
    localparam logic        DEF_EN    = (XY_SZ == 8) && (SEG_NUM == 8);
    localparam logic [63:0] DEF_BIAS  = 64'h07_0F_15_1A_1E_20_1F_1B;
    localparam logic [63:0] DEF_SLOPE = 64'h4F_46_3D_34_2B_22_19_0F;
    localparam logic [63:0] DEF_DEM   = 64'h6C_5C_49_33_18_F7_C9_80;
    localparam logic [XY_SZ-1:0] MOST_NEG = {1'b1, {(XY_SZ - 1){1'b0}}};

    localparam logic signed [XY_SZ+1:0] MAXV = {3'b000, {(XY_SZ - 1){1'b1}}};
    localparam logic signed [XY_SZ+1:0] MINV = {3'b111, {(XY_SZ - 1){1'b0}}};

    function automatic logic [XY_SZ-1:0] def_entry(input logic [63:0] tbl,
                                                   input logic [XY_SZ-1:0] fallback,
                                                   input int idx);
        if (DEF_EN) return XY_SZ'(tbl >> (8 * idx));
        return fallback;
    endfunction

    logic [XY_SZ-1:0] bias_tbl  [SEG_NUM];
    logic [XY_SZ-1:0] slope_tbl [SEG_NUM];
    logic [XY_SZ-1:0] dem_tbl   [SEG_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEG_NUM; i++) begin
                bias_tbl[i]  <= def_entry(DEF_BIAS, '0, i);
                slope_tbl[i] <= def_entry(DEF_SLOPE, '0, i);
                dem_tbl[i]   <= def_entry(DEF_DEM, MOST_NEG, i);
            end
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    bias_tbl[cfg_addr]  <= cfg_data;
                2'd1:    slope_tbl[cfg_addr] <= cfg_data;
                2'd2:    dem_tbl[cfg_addr]   <= cfg_data;
                default: ;
            endcase
        end
    end

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Highest qualifying index wins, so unsorted breakpoint tables still resolve deterministically.
    logic [SEG_W-1:0] seg;
    always_comb begin
        seg = '0;
        for (int i = 0; i < SEG_NUM; i++) begin
            if ($signed(in_angle) > $signed(dem_tbl[i])) seg = SEG_W'(i);
        end
    end

    logic                      s1_valid, s2_valid;
    logic [XY_SZ-1:0]          s1_angle, s1_slope, s1_bias, s2_bias;
    logic signed [2*XY_SZ-1:0] prod, s2_prod, prod_adj;
    logic signed [XY_SZ+1:0]   t, sum;
    logic [XY_SZ-1:0]          res_exp;
    logic                      res_sat;

    assign prod = $signed({{XY_SZ{s1_angle[XY_SZ-1]}}, s1_angle})
                * $signed({{XY_SZ{s1_slope[XY_SZ-1]}}, s1_slope});

`ifdef PWL_EXP_ROUND_EN
    localparam logic signed [2*XY_SZ-1:0] RND = (2 * XY_SZ)'(1) << (FRAC_IN - 1);
    assign prod_adj = s2_prod + RND;
`else
    assign prod_adj = s2_prod;
`endif

    assign t   = (XY_SZ + 2)'(prod_adj >>> FRAC_IN);
    assign sum = t + $signed({{2{s2_bias[XY_SZ-1]}}, s2_bias});

    always_comb begin
        res_exp = sum[XY_SZ-1:0];
        res_sat = 1'b0;
        if (sum > MAXV) begin
            res_exp = MAXV[XY_SZ-1:0];
            res_sat = 1'b1;
        end else if (sum < MINV) begin
            res_exp = MINV[XY_SZ-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_angle  <= '0;
            s1_slope  <= '0;
            s1_bias   <= '0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_bias   <= '0;
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_angle  <= in_angle;
            s1_slope  <= slope_tbl[seg];
            s1_bias   <= bias_tbl[seg];
            s2_valid  <= s1_valid;
            s2_prod   <= prod;
            s2_bias   <= s1_bias;
            out_valid <= s2_valid;
            out_exp   <= res_exp;
            out_sat   <= res_sat;
        end
    end

endmodule

// File: tb/tb_pwl_exp_pipe.sv
// Self-checking bench for pwl_exp_pipe: vector table plus scoreboard-checked corner sequences.
module tb_pwl_exp_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_sat, cfg_we;
    logic [7:0] in_angle, out_exp, cfg_data;
    logic [1:0] cfg_sel;
    logic [2:0] cfg_addr;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];
    logic [8:0] mon_e;

    typedef struct {
        logic [7:0] angle;
        logic [7:0] exp;
        logic       sat;
    } vec_t;
    vec_t vecs[10];

    pwl_exp_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_sat   (out_sat),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a transfer happens at the posedge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h, expected none", out_exp);
            end else begin
                mon_e = sb.pop_front();
                check("out_exp", {24'd0, out_exp}, {24'd0, mon_e[7:0]});
                check("out_sat", {31'd0, out_sat}, {31'd0, mon_e[8]});
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] e, input logic s,
                        input logic push);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_angle = a;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept, expected accept of %0h", a);
        end else if (push) begin
            sb.push_back({s, e});
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [2:0] addr, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        vecs[0] = '{8'h00, 8'h20, 1'b0};
        vecs[1] = '{8'h7F, 8'h55, 1'b0};
        vecs[2] = '{8'h80, 8'h0C, 1'b0};
        vecs[3] = '{8'h18, 8'h26, 1'b0};
        vecs[4] = '{8'h19, 8'h26, 1'b0};
        vecs[5] = '{8'hC9, 8'h14, 1'b0};
        vecs[6] = '{8'hF7, 8'h1D, 1'b0};
        vecs[7] = '{8'h40, 8'h34, 1'b0};
        vecs[8] = '{8'h33, 8'h2F, 1'b0};
        vecs[9] = '{8'h5C, 8'h40, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_angle = '0;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_sel = '0;
        cfg_addr = '0;
        cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_exp", {24'd0, out_exp}, 0);
        check("rst_out_sat", {31'd0, out_sat}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        rst = 1'b0;

        // Latency: out_valid first seen on the third negedge after the accepting edge.
        send(8'h00, 8'h20, 1'b0, 1'b1);
        lat = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("latency", lat, 3);
        drain();

        foreach (vecs[i]) send(vecs[i].angle, vecs[i].exp, vecs[i].sat, 1'b1);
        drain();

        cfg_write(2'd1, 3'd7, 8'h7F);
        cfg_write(2'd0, 3'd7, 8'h7F);
        send(8'h7F, 8'h7F, 1'b1, 1'b1);
        cfg_write(2'd1, 3'd0, 8'h7F);
        cfg_write(2'd0, 3'd0, 8'h80);
        send(8'h80, 8'h80, 1'b1, 1'b1);
        drain();

        // Backpressure with three samples in flight.
        do_reset();
        send(8'h00, 8'h20, 1'b0, 1'b1);
        send(8'h7F, 8'h55, 1'b0, 1'b1);
        send(8'h80, 8'h0C, 1'b0, 1'b1);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 0);
            check("stall_out_valid", {31'd0, out_valid}, 1);
            check("stall_out_exp", {24'd0, out_exp}, 32'h20);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Write racing the S1 lookup sees the old entry; cfg_sel 3 changes nothing.
        cfg_we   = 1'b1;
        cfg_sel  = 2'd0;
        cfg_addr = 3'd2;
        cfg_data = 8'h10;
        send(8'h00, 8'h20, 1'b0, 1'b1);
        cfg_we = 1'b0;
        send(8'h00, 8'h10, 1'b0, 1'b1);
        cfg_write(2'd3, 3'd2, 8'h55);
        send(8'h00, 8'h10, 1'b0, 1'b1);
        drain();

        // Reset with two samples in flight: nothing comes out, defaults return.
        send(8'h00, 8'h00, 1'b0, 1'b0);
        send(8'h7F, 8'h00, 1'b0, 1'b0);
        do_reset();
        repeat (4) begin
            @(negedge clk);
            check("flush_out_valid", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1;
        send(8'h00, 8'h20, 1'b0, 1'b1);
        drain();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
